pattern_gen: RTL and testbench



---
 rtl/pattern_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_pattern_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// pattern_gen: test-pattern source for the DVI transmitter.
//
// The block takes the pixel coordinate from the sync generator and returns its RGB colour
// one pixel-clock cycle later. Patterns are colour bars, checkerboard, gradient and an
// optional bouncing box. A debounced push-button steps the pattern, and a step takes
// effect only at the frame boundary.
//
// Optional feature: define PATTERN_GEN_BOX_EN to compile in the bouncing-box mode (four
// modes). Without it there are three modes and mode_o never reads 3.
//
// Ports:
//   clk_i    pixel clock, rising edge
//   rst_ni   asynchronous active-low reset
//   x_i      current pixel x
//   y_i      current pixel y
//   next_i   raw push-button, high = pressed (asynchronous)
//   red_o    registered red for the coordinate sampled on the previous edge
//   green_o  registered green
//   blue_o   registered blue
//   mode_o   active pattern: 0 bars, 1 checker, 2 gradient, 3 box
//   frame_o  one-cycle pulse, registered copy of the frame tick
module pattern_gen #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned BOX_SIZE        = 32,
  parameter int unsigned BOX_SPEED       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned X_POS_W         = 10,
  parameter int unsigned Y_POS_W         = 10,
  parameter int unsigned COLOR_W         = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  input  logic               next_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic [1:0]         mode_o,
  output logic               frame_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
`ifdef PATTERN_GEN_BOX_EN
  localparam logic [1:0] LAST_MODE = 2'd3;
`else
  localparam logic [1:0] LAST_MODE = 2'd2;
`endif

  // Button synchronizer and debouncer
  logic             sync_ff1;
  logic             sync_ff2;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;
  logic             db_hit;
  logic             db_rise;

  // Mode control
  logic       pending;
  logic [1:0] mode;
  logic       tick;
  logic       mode_step;

  // Colour datapath
  logic               visible;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] red_d;
  logic [COLOR_W-1:0] green_d;
  logic [COLOR_W-1:0] blue_d;

  assign tick = (x_i == '0) && (32'(y_i) == V_ACTIVE);

  // The synchronized value has differed from the debounced level for DEBOUNCE_CYCLES edges
  assign db_hit  = (sync_ff2 != db_level) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign db_rise = db_hit && sync_ff2;

  // A press landing in the same cycle as the tick still counts for this frame
  assign mode_step = tick && (pending || db_rise);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_ff1 <= next_i;
      sync_ff2 <= sync_ff1;
      if (sync_ff2 == db_level) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_level <= sync_ff2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= 1'b0;
      mode    <= 2'd0;
      frame_o <= 1'b0;
    end else begin
      frame_o <= tick;
      if (mode_step) begin
        pending <= 1'b0;
        mode    <= (mode == LAST_MODE) ? 2'd0 : mode + 2'd1;
      end else if (db_rise) begin
        // Extra presses while one is already pending are absorbed here
        pending <= 1'b1;
      end
    end
  end

  assign mode_o = mode;

`ifdef PATTERN_GEN_BOX_EN
  localparam logic [X_POS_W:0] LIMIT_X = (X_POS_W + 1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [Y_POS_W:0] LIMIT_Y = (Y_POS_W + 1)'(V_ACTIVE - BOX_SIZE);
  localparam logic [X_POS_W:0] SPEED_X = (X_POS_W + 1)'(BOX_SPEED);
  localparam logic [Y_POS_W:0] SPEED_Y = (Y_POS_W + 1)'(BOX_SPEED);

  logic [X_POS_W:0] box_x;
  logic [Y_POS_W:0] box_y;
  logic             box_x_neg;
  logic             box_y_neg;
  logic             in_box;

  // One extra bit of headroom keeps box + speed from wrapping near the right/bottom edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      box_x     <= '0;
      box_y     <= '0;
      box_x_neg <= 1'b0;
      box_y_neg <= 1'b0;
    end else if (tick) begin
      if (!box_x_neg) begin
        if (box_x + SPEED_X >= LIMIT_X) begin
          box_x     <= LIMIT_X;
          box_x_neg <= 1'b1;
        end else begin
          box_x <= box_x + SPEED_X;
        end
      end else if (box_x <= SPEED_X) begin
        box_x     <= '0;
        box_x_neg <= 1'b0;
      end else begin
        box_x <= box_x - SPEED_X;
      end

      if (!box_y_neg) begin
        if (box_y + SPEED_Y >= LIMIT_Y) begin
          box_y     <= LIMIT_Y;
          box_y_neg <= 1'b1;
        end else begin
          box_y <= box_y + SPEED_Y;
        end
      end else if (box_y <= SPEED_Y) begin
        box_y     <= '0;
        box_y_neg <= 1'b0;
      end else begin
        box_y <= box_y - SPEED_Y;
      end
    end
  end

  assign in_box = (32'(x_i) >= 32'(box_x)) && (32'(x_i) < 32'(box_x) + BOX_SIZE) &&
                  (32'(y_i) >= 32'(box_y)) && (32'(y_i) < 32'(box_y) + BOX_SIZE);
`endif

  assign visible = (32'(x_i) < H_ACTIVE) && (32'(y_i) < V_ACTIVE);
  assign bar_idx = 3'(32'(x_i) / BAR_W);

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (visible) begin
      case (mode)
        2'd0: begin
          // Bar order white, yellow, cyan, green, magenta, red, blue, black maps onto
          // the inverted index bits: red ~[1], green ~[2], blue ~[0]
          red_d   = {COLOR_W{~bar_idx[1]}};
          green_d = {COLOR_W{~bar_idx[2]}};
          blue_d  = {COLOR_W{~bar_idx[0]}};
        end
        2'd1: begin
          red_d   = {COLOR_W{x_i[5] ^ y_i[5]}};
          green_d = {COLOR_W{x_i[5] ^ y_i[5]}};
          blue_d  = {COLOR_W{x_i[5] ^ y_i[5]}};
        end
        2'd2: begin
          red_d   = COLOR_W'(x_i);
          green_d = COLOR_W'(y_i);
          blue_d  = COLOR_W'(32'(x_i) + 32'(y_i));
        end
`ifdef PATTERN_GEN_BOX_EN
        2'd3: begin
          red_d = {COLOR_W{in_box}};
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      red_o   <= red_d;
      green_o <= green_d;
      blue_o  <= blue_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Testbench for pattern_gen. Drives coordinates directly (a frame boundary is simply the
// coordinate (0, V_ACTIVE)), and compares outputs with a behavioural model of the patterns,
// the mode sequence and the box trajectory.
module tb_pattern_gen;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BS = 32;
  localparam int SP = 4;
`ifdef PATTERN_GEN_BOX_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       next;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [1:0] mode;
  logic       frame;

  always #5 clk = ~clk;

  pattern_gen #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .BOX_SIZE       (BS),
    .BOX_SPEED      (SP),
    .DEBOUNCE_CYCLES(16),
    .X_POS_W        (10),
    .Y_POS_W        (10),
    .COLOR_W        (8)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .x_i    (x),
    .y_i    (y),
    .next_i (next),
    .red_o  (red),
    .green_o(green),
    .blue_o (blue),
    .mode_o (mode),
    .frame_o(frame)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_mode    = 0;
  int m_pending = 0;
  int m_bx      = 0;
  int m_by      = 0;
  int m_vx      = SP;
  int m_vy      = SP;
  int m_ticks   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_pending = 0;
    m_bx      = 0;
    m_by      = 0;
    m_vx      = SP;
    m_vy      = SP;
    m_ticks   = 0;
  endtask

  function automatic logic [23:0] ref_color(input int px, input int py);
    if (px >= H || py >= V) return 24'h000000;
    case (m_mode)
      0: begin
        case (px / (H / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((px / 32) % 2) != ((py / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(px % 256), 8'(py % 256), 8'((px + py) % 256)};
      default: begin
        if (px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS) return 24'hFF0000;
        return 24'h000000;
      end
    endcase
  endfunction

  // Box moves by its velocity, clamped to the travel range; hitting an end reverses it
  task automatic model_box();
    int nx;
    int ny;
    nx = m_bx + m_vx;
    ny = m_by + m_vy;
    if (nx >= H - BS) begin nx = H - BS; m_vx = -m_vx; end
    else if (nx <= 0) begin nx = 0; m_vx = -m_vx; end
    if (ny >= V - BS) begin ny = V - BS; m_vy = -m_vy; end
    else if (ny <= 0) begin ny = 0; m_vy = -m_vy; end
    m_bx = nx;
    m_by = ny;
  endtask

  task automatic pix(input int px, input int py, input string tag);
    logic [23:0] exp;
    exp = ref_color(px, py);
    x = 10'(px);
    y = 10'(py);
    cyc();
    check(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  task automatic rand_pix(input int n);
    int px;
    int py;
    for (int i = 0; i < n; i++) begin
      px = int'($urandom_range(0, 700));
      py = int'($urandom_range(0, 520));
      if (px == 0 && py == V) px = 1;
      pix(px, py, "rand_pix");
      check("rand_frame", 32'(frame), 32'd0);
    end
  endtask

  task automatic do_tick();
    check("mode_pre_tick", 32'(mode), 32'(m_mode));
    x = 10'd0;
    y = 10'(V);
    cyc();
    if (m_pending != 0) begin
      m_mode    = (m_mode + 1) % NMODES;
      m_pending = 0;
    end
`ifdef PATTERN_GEN_BOX_EN
    model_box();
`endif
    m_ticks++;
    check("frame_pulse", 32'(frame), 32'd1);
    check("mode_at_frame", 32'(mode), 32'(m_mode));
    x = 10'd0;
    y = 10'd0;
    cyc();
    check("frame_end", 32'(frame), 32'd0);
  endtask

  // Hold the button for len cycles, then release long enough for the release to settle
  task automatic press(input int len);
    next = 1'b1;
    repeat (len) cyc();
    next = 1'b0;
    repeat (24) cyc();
    if (len >= 20) m_pending = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    next  = 1'b0;
    x     = 10'd0;
    y     = 10'd0;
    repeat (3) cyc();
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;

    pix(0, 0, "bar_white");
    check("bar_white_const", 32'({red, green, blue}), 32'hFFFFFF);
    pix(80, 10, "bar_yellow");
    check("bar_yellow_const", 32'({red, green, blue}), 32'hFFFF00);
    pix(639, 10, "bar_last");
    pix(640, 10, "h_blank");
    pix(10, 480, "v_blank");
    rand_pix(16);

    // Short glitches must not step the mode across two frames
    press(int'($urandom_range(1, 12)));
    press(int'($urandom_range(1, 12)));
    do_tick();
    do_tick();
    check("glitch_mode", 32'(mode), 32'd0);

    press(25);
    do_tick();
    check("mode_after_press", 32'(mode), 32'd1);
    rand_pix(16);

    // Two presses inside one frame give a single step
    press(int'($urandom_range(20, 40)));
    press(int'($urandom_range(20, 40)));
    do_tick();
    do_tick();
    check("double_press", 32'(mode), 32'd2);
    pix(300, 200, "gradient");
    check("gradient_const", 32'({red, green, blue}), 32'h2CC8F4);
    rand_pix(16);

    press(int'($urandom_range(20, 40)));
    do_tick();
`ifdef PATTERN_GEN_BOX_EN
    check("mode_wrap_step", 32'(mode), 32'd3);
`else
    check("mode_wrap_step", 32'(mode), 32'd0);
`endif
    rand_pix(16);

    if (m_mode == 0) begin
      press(30);
      do_tick();
    end

    // Mid-frame asynchronous reset
    if (m_mode == 3) pix(m_bx, m_by, "pre_rst_pix");
    else pix(40, 0, "pre_rst_pix");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_frame", 32'(frame), 32'd0);
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
    pix(0, 0, "post_rst_white");

`ifdef PATTERN_GEN_BOX_EN
    for (int i = 0; i < 3; i++) begin
      press(int'($urandom_range(20, 40)));
      do_tick();
    end
    check("box_mode", 32'(mode), 32'd3);
    while (m_ticks < 112) do_tick();
    pix(m_bx, 448, "box_y_top_112");
    pix(m_bx, 447, "box_y_above_112");
    do_tick();
    pix(m_bx, 444, "box_y_top_113");
    pix(m_bx, 476, "box_y_below_113");
    while (m_ticks < 152) do_tick();
    pix(608, m_by, "box_x_left_152");
    pix(607, m_by, "box_x_before_152");
    pix(m_bx, m_by, "box_corner");
    check("box_corner_red", 32'({red, green, blue}), 32'hFF0000);
    pix(m_bx + BS, m_by, "box_right_edge");
    check("box_right_black", 32'({red, green, blue}), 32'h000000);
    do_tick();
    pix(604, m_by, "box_x_left_153");
    pix(636, m_by, "box_x_right_153");
    for (int i = 0; i < 16; i++) begin
      pix(m_bx + int'($urandom_range(0, 72)) - 36, m_by + int'($urandom_range(0, 72)) - 36,
          "box_rand");
    end
`else
    check("no_box_mode", 32'(mode == 2'd3), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
